// File: rtl/fma_vec_checker_if.sv
`timescale 1ns/1ps
// fma_vec_checker_if: vector-memory read port plus the operand/result pins
// of the FMA under test. The checker is the master; the memory and the FMA
// together form the slave side.
interface fma_vec_checker_if #(
  parameter int FMTW = 16,
  parameter int AW   = 20
);
  localparam int VW = 4 * FMTW + 12;

  logic [AW-1:0]   mem_addr;
  logic [VW-1:0]   mem_rdata;
  logic [FMTW-1:0] dut_x;
  logic [FMTW-1:0] dut_y;
  logic [FMTW-1:0] dut_z;
  logic [1:0]      dut_roundmode;
  logic            dut_mul;
  logic            dut_add;
  logic            dut_negp;
  logic            dut_negz;
  logic [FMTW-1:0] dut_result;
  logic [3:0]      dut_flags;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output dut_x, dut_y, dut_z, dut_roundmode,
    output dut_mul, dut_add, dut_negp, dut_negz,
    input  dut_result, dut_flags
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  dut_x, dut_y, dut_z, dut_roundmode,
    input  dut_mul, dut_add, dut_negp, dut_negz,
    output dut_result, dut_flags
  );
endinterface

// File: rtl/fma_vec_checker.sv
`timescale 1ns/1ps
// fma_vec_checker: streams packed vectors {x, y, z, ctrl, rexp, flagsexp}
// from a synchronous-read memory into an FMA under test at one vector per
// cycle and compares the FMA result (and optionally its flags) against the
// expected values. Expected values travel in a valid-tagged delay line of
// depth LAT+1 so they line up with the FMA output.
module fma_vec_checker #(
  parameter int FMTW = 16,
  parameter int LAT  = 0,
  parameter int AW   = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    nvec_i,
  input  logic             cmp_flags_i,
  input  logic             stop_on_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_pulse_o,
  output logic [31:0]      errors_o,
  output logic             first_err_valid_o,
  output logic [AW-1:0]    first_err_idx_o,
  fma_vec_checker_if.master bus
);

  // Field positions inside a packed vector, MSB first.
  localparam int X_LSB    = 3 * FMTW + 12;
  localparam int Y_LSB    = 2 * FMTW + 12;
  localparam int Z_LSB    = FMTW + 12;
  localparam int CTL_LSB  = FMTW + 4;
  localparam int REXP_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Control and status registers.
  state_t          state_q;
  logic [AW-1:0]   nvec_q;
  logic [AW-1:0]   addr_q;
  logic            cmp_flags_q;
  logic            stop_on_err_q;
  logic            busy_q;
  logic            done_q;
  logic [31:0]     errors_q;
  logic            first_err_valid_q;
  logic [AW-1:0]   first_err_idx_q;

  // Read-data stage: index of the vector arriving on mem_rdata this cycle.
  logic            s1_vld_q;
  logic [AW-1:0]   s1_idx_q;

  // Operand registers driving the FMA.
  logic [FMTW-1:0] dut_x_q;
  logic [FMTW-1:0] dut_y_q;
  logic [FMTW-1:0] dut_z_q;
  logic [1:0]      dut_rm_q;
  logic            dut_mul_q;
  logic            dut_add_q;
  logic            dut_negp_q;
  logic            dut_negz_q;

  // Expected-value delay line; entry 0 is loaded with the operands,
  // entry LAT is aligned with the FMA result.
  logic [LAT:0]    dl_vld_q;
  logic [FMTW-1:0] dl_rexp_q [LAT+1];
  logic [3:0]      dl_fexp_q [LAT+1];
  logic [AW-1:0]   dl_idx_q  [LAT+1];

  // Unpacked view of the read data.
  logic [FMTW-1:0] v_x;
  logic [FMTW-1:0] v_y;
  logic [FMTW-1:0] v_z;
  logic [5:0]      v_ctl;
  logic [1:0]      unused_ctl_hi;
  logic [FMTW-1:0] v_rexp;
  logic [3:0]      v_fexp;

  // Per-cycle decisions.
  logic            issue;
  logic            mismatch;
  logic            stop_req;
  logic            at_last;
  logic            pend;
  logic [31:0]     errors_inc;

  // Result/flag comparison for one aligned vector.
  function automatic logic vec_mismatch(
    input logic [FMTW-1:0] res,
    input logic [FMTW-1:0] exp_res,
    input logic [3:0]      flg,
    input logic [3:0]      exp_flg,
    input logic            use_flags
  );
    vec_mismatch = (res != exp_res) | (use_flags & (flg != exp_flg));
  endfunction

  assign v_x           = bus.mem_rdata[X_LSB +: FMTW];
  assign v_y           = bus.mem_rdata[Y_LSB +: FMTW];
  assign v_z           = bus.mem_rdata[Z_LSB +: FMTW];
  assign v_ctl         = bus.mem_rdata[CTL_LSB +: 6];
  assign unused_ctl_hi = bus.mem_rdata[CTL_LSB + 6 +: 2];
  assign v_rexp        = bus.mem_rdata[REXP_LSB +: FMTW];
  assign v_fexp        = bus.mem_rdata[3:0];

  // Issue, compare, stop and drain conditions for the current cycle.
  always_comb begin
    issue    = (state_q == RUN);
    mismatch = 1'b0;
    if (dl_vld_q[LAT]) begin
      mismatch = vec_mismatch(bus.dut_result, dl_rexp_q[LAT],
                              bus.dut_flags, dl_fexp_q[LAT], cmp_flags_q);
    end else begin
      mismatch = 1'b0;
    end
    stop_req = stop_on_err_q & (mismatch | first_err_valid_q);
    at_last  = (addr_q == (nvec_q - AW'(1)));
    if (errors_q != 32'hFFFF_FFFF) begin
      errors_inc = errors_q + 32'd1;
    end else begin
      errors_inc = errors_q;
    end
    // Anything upstream of the final delay-line entry still holds a vector.
    pend = issue | s1_vld_q;
    for (int i = 0; i < LAT; i++) begin
      pend = pend | dl_vld_q[i];
    end
  end

  // Run-control FSM with error accounting and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      nvec_q            <= '0;
      addr_q            <= '0;
      cmp_flags_q       <= 1'b0;
      stop_on_err_q     <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      errors_q          <= 32'd0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
    end else begin
      // In-flight vectors are still counted while draining.
      if (mismatch) begin
        errors_q <= errors_inc;
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_idx_q   <= dl_idx_q[LAT];
        end
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            nvec_q            <= nvec_i;
            cmp_flags_q       <= cmp_flags_i;
            stop_on_err_q     <= stop_on_err_i;
            errors_q          <= 32'd0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            addr_q            <= '0;
            if (nvec_i == {AW{1'b0}}) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          // The address presented this cycle is issued either way.
          if (stop_req || at_last) begin
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (!pend) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers and the valid-tagged expected-value delay line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      dut_x_q    <= '0;
      dut_y_q    <= '0;
      dut_z_q    <= '0;
      dut_rm_q   <= 2'd0;
      dut_mul_q  <= 1'b0;
      dut_add_q  <= 1'b0;
      dut_negp_q <= 1'b0;
      dut_negz_q <= 1'b0;
      dl_vld_q   <= '0;
      for (int i = 0; i <= LAT; i++) begin
        dl_rexp_q[i] <= '0;
        dl_fexp_q[i] <= 4'd0;
        dl_idx_q[i]  <= '0;
      end
    end else begin
      s1_vld_q <= issue;
      s1_idx_q <= addr_q;
      if (s1_vld_q) begin
        dut_x_q      <= v_x;
        dut_y_q      <= v_y;
        dut_z_q      <= v_z;
        dut_rm_q     <= v_ctl[5:4];
        dut_mul_q    <= v_ctl[3];
        dut_add_q    <= v_ctl[2];
        dut_negp_q   <= v_ctl[1];
        dut_negz_q   <= v_ctl[0];
        dl_vld_q[0]  <= 1'b1;
        dl_rexp_q[0] <= v_rexp;
        dl_fexp_q[0] <= v_fexp;
        dl_idx_q[0]  <= s1_idx_q;
      end else begin
        dl_vld_q[0]  <= 1'b0;
      end
      for (int i = 1; i <= LAT; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_rexp_q[i] <= dl_rexp_q[i-1];
        dl_fexp_q[i] <= dl_fexp_q[i-1];
        dl_idx_q[i]  <= dl_idx_q[i-1];
      end
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.dut_x         = dut_x_q;
  assign bus.dut_y         = dut_y_q;
  assign bus.dut_z         = dut_z_q;
  assign bus.dut_roundmode = dut_rm_q;
  assign bus.dut_mul       = dut_mul_q;
  assign bus.dut_add       = dut_add_q;
  assign bus.dut_negp      = dut_negp_q;
  assign bus.dut_negz      = dut_negz_q;

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_pulse_o       = mismatch;
  assign errors_o          = errors_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_idx_o   = first_err_idx_q;

endmodule

// File: tb/tb_fma_vec_checker.sv
`timescale 1ns/1ps
// tb_fma_vec_checker: three checker instances (LAT 0, 2, 3), each with its
// own vector memory and a behavioural stand-in FMA. Expected vectors and
// expected per-vector mismatch flags are queued at start and popped when
// the corresponding cycle arrives.
module tb_fma_vec_checker;
  localparam int FMTW  = 16;
  localparam int AW    = 5;
  localparam int VW    = 4 * FMTW + 12;
  localparam int NI    = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a [NI];
  logic [AW-1:0] nvec_a  [NI];
  logic          cmpf_a  [NI];
  logic          stop_a  [NI];
  logic          busy_a  [NI];
  logic          done_a  [NI];
  logic          errp_a  [NI];
  logic [31:0]   errors_a[NI];
  logic          fev_a   [NI];
  logic [AW-1:0] fei_a   [NI];
  logic [AW-1:0] maddr_a [NI];
  logic [15:0]   dx_a    [NI];
  logic [15:0]   dy_a    [NI];
  logic [15:0]   dz_a    [NI];
  logic [5:0]    dctl_a  [NI];

  logic [VW-1:0] mem   [NI][DEPTH];
  bit            bad_r [NI][DEPTH];
  bit            bad_f [NI][DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  logic [VW-1:0] vq[$];
  bit            mq[$];

  // Stand-in FMA: c = {roundmode, mul, add, negp, negz}.
  function automatic logic [19:0] fma_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z, input logic [5:0] c);
    logic [15:0] r;
    logic [3:0]  f;
    r = (x ^ {y[7:0], y[15:8]}) + z + {10'd0, c};
    f = {r[15] ^ c[3], r[0] ^ c[0], c[2] ^ c[1], c[5]};
    return {r, f};
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 0 : u + 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 0 : g + 1;
    fma_vec_checker_if #(.FMTW(FMTW), .AW(AW)) bus ();
    logic [19:0] rf;

    fma_vec_checker #(.FMTW(FMTW), .LAT(L), .AW(AW)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start_a[g]),
      .nvec_i            (nvec_a[g]),
      .cmp_flags_i       (cmpf_a[g]),
      .stop_on_err_i     (stop_a[g]),
      .busy_o            (busy_a[g]),
      .done_o            (done_a[g]),
      .err_pulse_o       (errp_a[g]),
      .errors_o          (errors_a[g]),
      .first_err_valid_o (fev_a[g]),
      .first_err_idx_o   (fei_a[g]),
      .bus               (bus)
    );

    always_ff @(posedge clk) bus.mem_rdata <= mem[g][bus.mem_addr];

    assign rf = fma_model(bus.dut_x, bus.dut_y, bus.dut_z,
                          {bus.dut_roundmode, bus.dut_mul, bus.dut_add, bus.dut_negp, bus.dut_negz});

    if (L == 0) begin : g_comb
      assign bus.dut_result = rf[19:4];
      assign bus.dut_flags  = rf[3:0];
    end else begin : g_pipe
      logic [19:0] sh [L];
      always_ff @(posedge clk) begin
        sh[0] <= rf;
        for (int j = 1; j < L; j++) sh[j] <= sh[j-1];
      end
      assign bus.dut_result = sh[L-1][19:4];
      assign bus.dut_flags  = sh[L-1][3:0];
    end

    assign maddr_a[g] = bus.mem_addr;
    assign dx_a[g]    = bus.dut_x;
    assign dy_a[g]    = bus.dut_y;
    assign dz_a[g]    = bus.dut_z;
    assign dctl_a[g]  = {bus.dut_roundmode, bus.dut_mul, bus.dut_add, bus.dut_negp, bus.dut_negz};
  end

  task automatic fill(input int u);
    for (int k = 0; k < DEPTH; k++) begin
      logic [15:0] x, y, z;
      logic [7:0]  ctl;
      logic [19:0] r;
      x   = 16'($urandom) | 16'h0001;
      y   = 16'($urandom);
      z   = 16'($urandom);
      ctl = 8'($urandom);
      if (k == 0) begin
        x = 16'h3c00; y = 16'h3c00; z = 16'h0000; ctl = 8'h00;
      end
      r = fma_model(x, y, z, ctl[5:0]);
      mem[u][k]   = {x, y, z, ctl, r};
      bad_r[u][k] = 1'b0;
      bad_f[u][k] = 1'b0;
    end
  endtask

  task automatic corrupt_r(input int u, input int k);
    mem[u][k][4] = ~mem[u][k][4];
    bad_r[u][k]  = 1'b1;
  endtask

  task automatic corrupt_f(input int u, input int k);
    mem[u][k][0] = ~mem[u][k][0];
    bad_f[u][k]  = 1'b1;
  endtask

  // One run on instance u, checked cycle by cycle from the scoreboard.
  task automatic run(input int u, input int nv, input logic cmpf, input logic stp,
                     input int poke_t, input string nm);
    int L, first, last, exp_err, t_done;
    logic [VW-1:0] v;
    logic [AW-1:0] ea;
    bit m, mis, eb, ed;
    L = lat_of(u); first = -1; exp_err = 0; last = nv - 1;
    for (int k = 0; k < nv; k++) begin
      mis = bad_r[u][k] | (cmpf & bad_f[u][k]);
      if (mis && first < 0) first = k;
    end
    if (stp && first >= 0 && first + 2 + L < last) last = first + 2 + L;
    vq.delete(); mq.delete();
    for (int k = 0; k <= last; k++) begin
      mis = bad_r[u][k] | (cmpf & bad_f[u][k]);
      vq.push_back(mem[u][k]);
      mq.push_back(mis);
      if (mis) exp_err++;
    end
    t_done = (nv == 0) ? 1 : 4 + last + L;
    @(negedge clk);
    start_a[u] = 1'b1; nvec_a[u] = AW'(nv); cmpf_a[u] = cmpf; stop_a[u] = stp;
    for (int t = 1; t <= t_done + 2; t++) begin
      @(negedge clk);
      start_a[u] = (t == poke_t);
      if (t == poke_t) begin
        nvec_a[u] = '0; cmpf_a[u] = ~cmpf; stop_a[u] = ~stp;
      end
      if (t >= 3 && vq.size() > 0) begin
        v = vq.pop_front();
        n_checks++;
        if ({dx_a[u], dy_a[u], dz_a[u], dctl_a[u]} !== {v[75:28], v[25:20]}) begin
          n_err++;
          $display("FAIL %s dut_vec t=%0d got %h want %h", nm, t,
                   {dx_a[u], dy_a[u], dz_a[u], dctl_a[u]}, {v[75:28], v[25:20]});
        end
      end
      m = 1'b0;
      if (t >= 3 + L && mq.size() > 0) m = mq.pop_front();
      n_checks++;
      if (errp_a[u] !== m) begin
        n_err++;
        $display("FAIL %s err_pulse t=%0d got %b want %b", nm, t, errp_a[u], m);
      end
      if (nv == 0) ea = '0;
      else if (t <= last + 1) ea = AW'(t - 1);
      else ea = AW'(last);
      n_checks++;
      if (maddr_a[u] !== ea) begin
        n_err++;
        $display("FAIL %s mem_addr t=%0d got %0d want %0d", nm, t, maddr_a[u], ea);
      end
      eb = (nv != 0) && (t < t_done);
      ed = (t >= t_done);
      n_checks++;
      if (busy_a[u] !== eb || done_a[u] !== ed) begin
        n_err++;
        $display("FAIL %s busy_done t=%0d got %b%b want %b%b", nm, t, busy_a[u], done_a[u], eb, ed);
      end
    end
    n_checks++;
    if (errors_a[u] !== 32'(exp_err)) begin
      n_err++;
      $display("FAIL %s errors got %0d want %0d", nm, errors_a[u], exp_err);
    end
    n_checks++;
    if (fev_a[u] !== (first >= 0)) begin
      n_err++;
      $display("FAIL %s first_err_valid got %b want %b", nm, fev_a[u], (first >= 0));
    end
    if (first >= 0) begin
      n_checks++;
      if (fei_a[u] !== AW'(first)) begin
        n_err++;
        $display("FAIL %s first_err_idx got %0d want %0d", nm, fei_a[u], first);
      end
    end
  endtask

  task automatic check_idle_zero(input int u, input string nm);
    n_checks++;
    if ({busy_a[u], done_a[u], errp_a[u], fev_a[u]} !== 4'b0000 || errors_a[u] !== 32'd0 ||
        fei_a[u] !== '0 || maddr_a[u] !== '0 ||
        {dx_a[u], dy_a[u], dz_a[u], dctl_a[u]} !== 54'd0) begin
      n_err++;
      $display("FAIL %s u=%0d got bdpv=%b%b%b%b errors=%0d idx=%0d addr=%0d x=%h want all zero",
               nm, u, busy_a[u], done_a[u], errp_a[u], fev_a[u], errors_a[u], fei_a[u],
               maddr_a[u], dx_a[u]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < NI; u++) check_idle_zero(u, "reset");
    rst = 1'b0;
  endtask

  task automatic test_all_match();
    fill(0);
    run(0, 3, 1'b1, 1'b0, 0, "all_match");
  endtask

  task automatic test_rexp_mismatch();
    fill(1);
    corrupt_r(1, 3);
    run(1, 5, 1'b1, 1'b0, 0, "rexp_mismatch");
  endtask

  task automatic test_flag_only();
    fill(0);
    corrupt_f(0, 0);
    run(0, 2, 1'b0, 1'b0, 0, "flag_ignored");
    run(0, 2, 1'b1, 1'b0, 0, "flag_compared");
  endtask

  task automatic test_stop_on_err();
    fill(2);
    corrupt_r(2, 2); corrupt_r(2, 3); corrupt_r(2, 8); corrupt_r(2, 9);
    run(2, 10, 1'b1, 1'b1, 0, "stop_on_err");
  endtask

  task automatic test_reset_mid_run();
    fill(0);
    corrupt_r(0, 0);
    @(negedge clk);
    start_a[0] = 1'b1; nvec_a[0] = AW'(8); cmpf_a[0] = 1'b1; stop_a[0] = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
    end
    n_checks++;
    if (errors_a[0] !== 32'd1 || busy_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset errors=%0d busy=%b want 1 1", errors_a[0], busy_a[0]);
    end
    rst = 1'b1;
    #1;
    check_idle_zero(0, "reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    fill(0);
    run(0, 8, 1'b1, 1'b0, 0, "rerun_after_reset");
  endtask

  task automatic test_nvec_zero();
    run(1, 0, 1'b1, 1'b0, 0, "nvec_zero");
  endtask

  task automatic test_start_while_busy();
    fill(2);
    corrupt_r(2, 5);
    run(2, 15, 1'b1, 1'b0, 13, "start_while_busy");
  endtask

  task automatic test_back_to_back();
    fill(1);
    corrupt_r(1, 0); corrupt_f(1, 4); corrupt_r(1, 5);
    run(1, 6, 1'b1, 1'b0, 0, "b2b_first");
    run(1, 4, 1'b0, 1'b1, 0, "b2b_second");
  endtask

  initial begin
    for (int u = 0; u < NI; u++) begin
      start_a[u] = 1'b0; nvec_a[u] = '0; cmpf_a[u] = 1'b0; stop_a[u] = 1'b0;
      fill(u);
    end
    test_reset();
    test_all_match();
    test_rexp_mismatch();
    test_flag_only();
    test_stop_on_err();
    test_reset_mid_run();
    test_nvec_zero();
    test_start_while_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
